mysystem_capture_ctrl: RTL and testbench
========================================

// Module: mysystem_capture_ctrl
// PURPOSE
//  Downstream consumer of the single-bit software PIO output (capture request level).
//  Turns the request into frame-aligned capture of NUM_FRAMES camera frames.
//  Gates the camera pixel stream (already synchronous to clk) toward the frame buffer writer.
//  Reports busy/done/abort/timeout status and per-frame line/pixel geometry for software readback.
// PARAMETERS
//  DATA_W      12     camera pixel data width
//  NUM_FRAMES  1      frames captured per request (>=1)
//  COUNT_W     16     width of frame/line/pixel counters (saturating)
//  TIMEOUT_CYC 2**24  max cycles in ARMED+WAIT_SOF before timeout (>=2)
// PORTS
//  clk            in   1        system clock
//  reset          in   1        synchronous, active-high reset
//  start_req      in   1        capture request level, from PIO out_port
//  frame_valid    in   1        camera frame valid
//  line_valid     in   1        camera line valid
//  pix_data       in   DATA_W   camera pixel data
//  cap_valid      out  1        registered: captured pixel valid
//  cap_data       out  DATA_W   registered: captured pixel data
//  cap_sof        out  1        registered: 1 with first captured pixel slot of each frame
//  busy           out  1        state is ARMED, WAIT_SOF or CAPTURE
//  done           out  1        state is DONE
//  aborted        out  1        sticky: request dropped before NUM_FRAMES completed
//  timeout        out  1        sticky: no SOF within TIMEOUT_CYC
//  frames_done    out  COUNT_W  frames completed this request
//  last_lines     out  COUNT_W  lines in last completed frame
//  last_line_len  out  COUNT_W  pixels in last completed line
// BEHAVIOUR
//  Reset: state IDLE; every output and counter 0; edge-detect registers 0.
//  Edges (registered prior value): req_rise = start_req & ~req_d; sof = frame_valid & ~fv_d;
//   eof = ~frame_valid & fv_d; eol = ~line_valid & lv_d.
//  IDLE: req_rise -> ARMED; clears aborted, timeout, frames_done, last_lines, last_line_len, tmo counter.
//  ARMED: ~start_req -> IDLE (aborted=1); else ~frame_valid -> WAIT_SOF (skips the partial frame).
//  WAIT_SOF: ~start_req -> IDLE (aborted=1); else sof -> CAPTURE.
//  Timeout: counter runs in ARMED/WAIT_SOF, cleared on entering CAPTURE; at TIMEOUT_CYC-1 -> DONE, timeout=1.
//   Priority in ARMED/WAIT_SOF: ~start_req > timeout > normal transition.
//  CAPTURE: start_req low sets abort_pending; the frame always completes (no partial frames).
//   eof: frames_done+1; -> DONE if frames_done+1==NUM_FRAMES or abort_pending
//   (aborted=1 only if count not reached), else -> WAIT_SOF.
//  DONE: held while start_req high; ~start_req -> IDLE. A new request needs a fresh req_rise.
//  Gate: qual = frame_valid & line_valid & (state==CAPTURE | (state==WAIT_SOF & sof & start_req)).
//   The sof cycle counts as captured. Latency 1 cycle:
//   cap_valid<=qual; cap_data<=pix_data when qual, else held; cap_sof<=qual & first-of-frame flag.
//  Geometry: pix_cnt++ on qual; on eol in capture: last_line_len<=pix_cnt(+1 if qual same cycle),
//   line_cnt++, pix_cnt<=0. On eof: last_lines<=line_cnt (+1 if eol same cycle), line_cnt<=0.
//   eol with pix_cnt==0 is not counted as a line.
//  Counters saturate at 2**COUNT_W-1; no wrap.
//  sof and eof in one cycle cannot occur (fv_d makes them exclusive).
//  Reset mid-capture: immediate IDLE; cap_valid drops the next cycle.
// TESTING
//  1: NUM_FRAMES=1, req rises mid-frame -> that frame skipped; next frame (4 lines x 8 px)
//     gives 32 cap_valid, cap_sof once, last_lines=4, last_line_len=8, done=1.
//  2: NUM_FRAMES=3, three 2x5 frames -> frames_done 1,2,3; WAIT_SOF between frames; done after 3rd eof.
//  3: req falls in CAPTURE at line 2 of 4 -> rest of frame captured; DONE, aborted=1, frames_done=1 (NUM_FRAMES=3).
//  4: TIMEOUT_CYC=100, frame_valid held low -> DONE, timeout=1 at cycle 100 after arm; req low -> IDLE.
//  5: req falls in WAIT_SOF -> IDLE, aborted=1, no cap_valid. Reset during CAPTURE -> all outputs 0 next cycle.
//  6: line_valid and frame_valid fall together on last pixel -> last_lines includes that line, last_line_len correct.

Source files
------------

// File: rtl/mysystem_capture_ctrl.sv
// Frame-aligned camera capture controller driven by a PIO request level.
// Gates the pixel stream and reports status and per-frame geometry.
module mysystem_capture_ctrl #(
    parameter int DATA_W      = 12,
    parameter int NUM_FRAMES  = 1,
    parameter int COUNT_W     = 16,
    parameter int TIMEOUT_CYC = 2**24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_req,
    input  logic               frame_valid,
    input  logic               line_valid,
    input  logic [DATA_W-1:0]  pix_data,
    output logic               cap_valid,
    output logic [DATA_W-1:0]  cap_data,
    output logic               cap_sof,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               timeout,
    output logic [COUNT_W-1:0] frames_done,
    output logic [COUNT_W-1:0] last_lines,
    output logic [COUNT_W-1:0] last_line_len
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WAIT_SOF,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic req_prev_q, req_prev_d;
    logic fv_prev_q, fv_prev_d;
    logic lv_prev_q, lv_prev_d;

    logic abort_pend_q, abort_pend_d;
    logic first_q, first_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic [COUNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [COUNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [COUNT_W-1:0] frames_done_q, frames_done_d;
    logic [COUNT_W-1:0] last_lines_q, last_lines_d;
    logic [COUNT_W-1:0] last_line_len_q, last_line_len_d;

    logic aborted_q, aborted_d;
    logic timeout_q, timeout_d;

    logic              cap_valid_q, cap_valid_d;
    logic [DATA_W-1:0] cap_data_q, cap_data_d;
    logic              cap_sof_q, cap_sof_d;

    logic req_rise;
    logic sof;
    logic eof;
    logic eol;
    logic tmo_hit;
    logic arm;
    logic in_cap;
    logic in_wait;
    logic qual;
    logic line_done;
    logic first_now;
    logic count_reached;
    logic [COUNT_W-1:0] frames_inc;

    function automatic logic [COUNT_W-1:0] sat_inc(
        input logic [COUNT_W-1:0] v
    );
        return (v == CNT_MAX) ? v : v + COUNT_W'(1);
    endfunction

    assign req_rise = start_req & ~req_prev_q;
    assign sof      = frame_valid & ~fv_prev_q;
    assign eof      = ~frame_valid & fv_prev_q;
    assign eol      = ~line_valid & lv_prev_q;
    assign tmo_hit  = (tmo_q == TMO_LAST);
    assign in_cap   = (state_q == S_CAPTURE);
    assign in_wait  = (state_q == S_WAIT_SOF);

    assign frames_inc    = sat_inc(frames_done_q);
    assign count_reached = (int'(frames_done_q) + 1) == NUM_FRAMES;

    assign qual = frame_valid & line_valid
                & (in_cap | (in_wait & sof & start_req));

    assign line_done = in_cap & eol & (pix_cnt_q != '0);
    assign first_now = in_wait | first_q;

    // Request sequencing: arm, skip partial frame, capture, finish.
    always_comb begin
        state_d      = state_q;
        aborted_d    = aborted_q;
        timeout_d    = timeout_q;
        abort_pend_d = 1'b0;
        tmo_d        = tmo_q;
        arm          = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_rise) begin
                    state_d   = S_ARMED;
                    arm       = 1'b1;
                    aborted_d = 1'b0;
                    timeout_d = 1'b0;
                    tmo_d     = '0;
                end
            end
            S_ARMED: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (!start_req) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (tmo_hit) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else if (!frame_valid) begin
                    state_d = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (!start_req) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (tmo_hit) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else if (sof) begin
                    state_d = S_CAPTURE;
                    tmo_d   = '0;
                end
            end
            S_CAPTURE: begin
                abort_pend_d = abort_pend_q | ~start_req;
                if (eof) begin
                    abort_pend_d = 1'b0;
                    if (count_reached) begin
                        state_d = S_DONE;
                    end else if (abort_pend_q | ~start_req) begin
                        state_d   = S_DONE;
                        aborted_d = 1'b1;
                    end else begin
                        state_d = S_WAIT_SOF;
                    end
                end
            end
            S_DONE: begin
                if (!start_req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pixel gate, edge history and saturating geometry counters.
    always_comb begin
        req_prev_d = start_req;
        fv_prev_d  = frame_valid;
        lv_prev_d  = line_valid;

        cap_valid_d = qual;
        cap_data_d  = qual ? pix_data : cap_data_q;
        cap_sof_d   = qual & first_now;

        first_d = 1'b0;
        if (in_wait || in_cap) begin
            first_d = first_now & ~qual;
        end

        pix_cnt_d       = pix_cnt_q;
        line_cnt_d      = line_cnt_q;
        frames_done_d   = frames_done_q;
        last_lines_d    = last_lines_q;
        last_line_len_d = last_line_len_q;

        if (arm) begin
            pix_cnt_d       = '0;
            line_cnt_d      = '0;
            frames_done_d   = '0;
            last_lines_d    = '0;
            last_line_len_d = '0;
        end else begin
            if (in_cap && (eol || eof)) begin
                pix_cnt_d = '0;
            end else if (qual) begin
                pix_cnt_d = sat_inc(pix_cnt_q);
            end
            if (line_done) begin
                last_line_len_d = pix_cnt_q;
                line_cnt_d      = sat_inc(line_cnt_q);
            end
            if (in_cap && eof) begin
                frames_done_d = frames_inc;
                line_cnt_d    = '0;
                last_lines_d  = line_done ? sat_inc(line_cnt_q)
                                          : line_cnt_q;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            req_prev_q      <= 1'b0;
            fv_prev_q       <= 1'b0;
            lv_prev_q       <= 1'b0;
            abort_pend_q    <= 1'b0;
            first_q         <= 1'b0;
            tmo_q           <= '0;
            pix_cnt_q       <= '0;
            line_cnt_q      <= '0;
            frames_done_q   <= '0;
            last_lines_q    <= '0;
            last_line_len_q <= '0;
            aborted_q       <= 1'b0;
            timeout_q       <= 1'b0;
            cap_valid_q     <= 1'b0;
            cap_data_q      <= '0;
            cap_sof_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_prev_q      <= req_prev_d;
            fv_prev_q       <= fv_prev_d;
            lv_prev_q       <= lv_prev_d;
            abort_pend_q    <= abort_pend_d;
            first_q         <= first_d;
            tmo_q           <= tmo_d;
            pix_cnt_q       <= pix_cnt_d;
            line_cnt_q      <= line_cnt_d;
            frames_done_q   <= frames_done_d;
            last_lines_q    <= last_lines_d;
            last_line_len_q <= last_line_len_d;
            aborted_q       <= aborted_d;
            timeout_q       <= timeout_d;
            cap_valid_q     <= cap_valid_d;
            cap_data_q      <= cap_data_d;
            cap_sof_q       <= cap_sof_d;
        end
    end

    assign cap_valid     = cap_valid_q;
    assign cap_data      = cap_data_q;
    assign cap_sof       = cap_sof_q;
    assign busy          = in_cap | in_wait | (state_q == S_ARMED);
    assign done          = (state_q == S_DONE);
    assign aborted       = aborted_q;
    assign timeout       = timeout_q;
    assign frames_done   = frames_done_q;
    assign last_lines    = last_lines_q;
    assign last_line_len = last_line_len_q;

endmodule

// File: tb/tb_mysystem_capture_ctrl.sv
// Bench for mysystem_capture_ctrl: random frames against a
// transaction-level expectation of captured pixels and status.
module tb_mysystem_capture_ctrl;

    localparam int DW  = 12;
    localparam int NF  = 3;
    localparam int CW  = 4;
    localparam int TMO = 100;
    localparam int CMAX = 2**CW - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_req;
    logic          frame_valid;
    logic          line_valid;
    logic [DW-1:0] pix_data;
    logic          cap_valid;
    logic [DW-1:0] cap_data;
    logic          cap_sof;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          timeout;
    logic [CW-1:0] frames_done;
    logic [CW-1:0] last_lines;
    logic [CW-1:0] last_line_len;

    int n_vec = 0;
    int n_err = 0;
    int last_np;
    logic [DW:0] exp_q[$];
    logic [DW:0] exp_e;

    mysystem_capture_ctrl #(
        .DATA_W(DW),
        .NUM_FRAMES(NF),
        .COUNT_W(CW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_req(start_req),
        .frame_valid(frame_valid),
        .line_valid(line_valid),
        .pix_data(pix_data),
        .cap_valid(cap_valid),
        .cap_data(cap_data),
        .cap_sof(cap_sof),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .timeout(timeout),
        .frames_done(frames_done),
        .last_lines(last_lines),
        .last_line_len(last_line_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int smin(input int a);
        return (a > CMAX) ? CMAX : a;
    endfunction

    task automatic cyc(input bit fv, input bit lv);
        frame_valid = fv;
        line_valid  = lv;
        @(posedge clk);
        #1;
    endtask

    // One camera frame; cap selects whether its pixels are expected.
    task automatic frame(input int nl, input int npf, input bit cap,
                         input bit tail, input int drop_line);
        bit first;
        int np;
        first = 1'b1;
        repeat ($urandom_range(0, 2)) cyc(1, 0);
        for (int l = 0; l < nl; l++) begin
            if (l == drop_line) start_req = 1'b0;
            np = (npf > 0) ? npf : int'($urandom_range(1, 20));
            for (int p = 0; p < np; p++) begin
                pix_data = DW'($urandom);
                if (cap) begin
                    exp_q.push_back({first, pix_data});
                    first = 1'b0;
                end
                cyc(1, 1);
            end
            last_np = np;
            if (!(tail && l == nl - 1)) begin
                repeat ($urandom_range(1, 3)) cyc(1, 0);
            end
        end
        cyc(0, 0);
    endtask

    // Scoreboard on the captured stream.
    always @(negedge clk) begin
        if (cap_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexp_cap", 32'(cap_valid), 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("cap", 32'({cap_sof, cap_data}), 32'(exp_e));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nl;
        int cnt;
        reset       = 1'b1;
        start_req   = 1'b0;
        frame_valid = 1'b0;
        line_valid  = 1'b0;
        pix_data    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", 32'({cap_valid, cap_sof, busy, done,
                                aborted, timeout}), 32'd0);
        check("rst_cnt", 32'({frames_done, last_lines,
                              last_line_len}), 32'd0);
        check("rst_data", 32'(cap_data), 32'd0);
        reset = 1'b0;
        cyc(0, 0);
        check("idle_busy", 32'({busy, done}), 32'd0);

        // Partial frame skipped, then NF full frames.
        for (int it = 0; it < 3; it++) begin
            k = $urandom_range(1, 3);
            fork
                frame(3, 4, 1'b0, 1'b0, -1);
                begin
                    repeat (k) @(posedge clk);
                    #1;
                    start_req = 1'b1;
                end
            join
            for (int f = 0; f < NF; f++) begin
                nl = $urandom_range(1, 6);
                repeat ($urandom_range(0, 4)) cyc(0, 0);
                frame(nl, 0, 1'b1, (f == 1), -1);
                check("fdone", 32'(frames_done), 32'(f + 1));
                check("busy", 32'(busy), 32'(f < NF - 1));
                check("done", 32'(done), 32'(f == NF - 1));
                check("lines", 32'(last_lines), 32'(smin(nl)));
                check("llen", 32'(last_line_len), 32'(smin(last_np)));
            end
            check("no_abort", 32'({aborted, timeout}), 32'd0);
            start_req = 1'b0;
            cyc(0, 0);
            check("to_idle", 32'({busy, done}), 32'd0);
            check("fdone_hold", 32'(frames_done), 32'(NF));
            check("q_empty", 32'(exp_q.size()), 32'd0);
        end

        // Request dropped mid-frame: frame completes, then abort.
        start_req = 1'b1;
        cyc(0, 0);
        cyc(0, 0);
        frame(4, 0, 1'b1, 1'b0, 2);
        check("ab_done", 32'({busy, done, aborted}), 32'b011);
        check("ab_fdone", 32'(frames_done), 32'd1);
        check("ab_lines", 32'(last_lines), 32'd4);
        check("ab_llen", 32'(last_line_len), 32'(smin(last_np)));
        cyc(0, 0);
        check("ab_idle", 32'({busy, done, aborted}), 32'b001);

        // No SOF: timeout after TMO cycles in ARMED/WAIT_SOF.
        start_req = 1'b1;
        cyc(0, 0);
        check("tm_arm", 32'({busy, aborted}), 32'b10);
        cnt = 0;
        while (done !== 1'b1 && cnt < 200) begin
            cyc(0, 0);
            cnt++;
        end
        check("tm_cycles", 32'(cnt), 32'(TMO));
        check("tm_flags", 32'({busy, timeout, aborted}), 32'b010);
        check("tm_fdone", 32'(frames_done), 32'd0);
        start_req = 1'b0;
        cyc(0, 0);
        check("tm_idle", 32'({done, timeout}), 32'b01);

        // Request dropped while waiting for SOF.
        start_req = 1'b1;
        cyc(0, 0);
        check("ws_clr", 32'(timeout), 32'd0);
        repeat (5) cyc(0, 0);
        check("ws_busy", 32'(busy), 32'd1);
        start_req = 1'b0;
        cyc(0, 0);
        check("ws_abort", 32'({busy, done, aborted}), 32'b001);

        // Reset in the middle of a captured line.
        start_req = 1'b1;
        cyc(0, 0);
        check("rc_clr", 32'(aborted), 32'd0);
        cyc(0, 0);
        for (int p = 0; p < 3; p++) begin
            pix_data = DW'($urandom);
            exp_q.push_back({(p == 0), pix_data});
            cyc(1, 1);
        end
        pix_data  = DW'($urandom);
        start_req = 1'b0;
        reset     = 1'b1;
        cyc(1, 1);
        check("rc_flags", 32'({cap_valid, cap_sof, busy, done,
                               aborted, timeout}), 32'd0);
        check("rc_data", 32'(cap_data), 32'd0);
        check("rc_cnt", 32'({frames_done, last_lines,
                             last_line_len}), 32'd0);
        reset = 1'b0;
        cyc(0, 0);
        cyc(0, 0);
        check("rc_q", 32'(exp_q.size()), 32'd0);
        check("rc_idle", 32'(busy), 32'd0);

        // Saturation, with line and frame valid falling together.
        start_req = 1'b1;
        cyc(0, 0);
        cyc(0, 0);
        frame(17, 20, 1'b1, 1'b1, -1);
        check("sat_fdone", 32'(frames_done), 32'd1);
        check("sat_lines", 32'(last_lines), 32'(CMAX));
        check("sat_llen", 32'(last_line_len), 32'(CMAX));
        check("sat_busy", 32'(busy), 32'd1);
        start_req = 1'b0;
        cyc(0, 0);
        check("sat_abort", 32'({busy, aborted}), 32'b01);
        check("sat_q", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
